// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - aggregates per-test ERROR/done flags into one registered pass/fail verdict
module test_result_monitor #(
  parameter int N_TESTS = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [N_TESTS-1:0]             error_in,
  input  logic [N_TESTS-1:0]             done_in,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [N_TESTS-1:0]             fail_mask,
  output logic [7:0]                     err_count,
  output logic [$clog2(TIMEOUT+1)-1:0]   cycles
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] CYC_LAST    = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [SW-1:0]        settle_cnt_q;
  logic [N_TESTS-1:0]   sticky_q;
  logic [N_TESTS-1:0]   prev_q;
  logic [N_TESTS-1:0]   fail_mask_q;
  logic [7:0]           err_count_q;
  logic [CW-1:0]        cycles_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 timeout_q;

  logic [N_TESTS-1:0]   rise;
  logic [N_TESTS-1:0]   fail_mask_d;
  logic [N_TESTS-1:0]   sticky_d;
  logic [5:0]           rise_pop;
  logic [9:0]           err_sum;
  logic [7:0]           err_count_d;
  logic [CW-1:0]        cycles_d;
  logic                 all_done;

  // RUN-cycle accumulation: edge detection, sticky masks, saturating error count
  always_comb begin
    rise        = error_in & ~prev_q;
    fail_mask_d = fail_mask_q | error_in;
    sticky_d    = sticky_q | done_in;
    all_done    = &sticky_d;
    cycles_d    = cycles_q + CW'(1);
    rise_pop    = '0;
    for (int i = 0; i < N_TESTS; i++) begin
      rise_pop = rise_pop + 6'(rise[i]);
    end
    err_sum     = {2'b00, err_count_q} + {4'b0000, rise_pop};
    err_count_d = (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
  end

  // Run-control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      sticky_q     <= '0;
      prev_q       <= '0;
      fail_mask_q  <= '0;
      err_count_q  <= '0;
      cycles_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sticky_q     <= '0;
            prev_q       <= '0;
            fail_mask_q  <= '0;
            err_count_q  <= '0;
            cycles_q     <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            state_q      <= (SETTLE == 0) ? S_RUN : S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Test tops are still in their initial blocks; inputs are not trusted yet
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= S_RUN;
          end else begin
            settle_cnt_q <= settle_cnt_q + SW'(1);
          end
        end
        S_RUN: begin
          prev_q      <= error_in;
          fail_mask_q <= fail_mask_d;
          err_count_q <= err_count_d;
          sticky_q    <= sticky_d;
          cycles_q    <= cycles_d;
          // All-done is checked first so a finish on the last allowed cycle is not a timeout
          if (all_done) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
            pass_q    <= (fail_mask_d == '0);
          end else if (cycles_q == CYC_LAST) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_count_q;
  assign cycles    = cycles_q;

endmodule
